delay_line_sram_ctrl: RTL and testbench
=======================================

Name: delay_line_sram_ctrl

Overview:
- Circular delay-line controller for the external 16-bit SRAM, directly upstream of the time-based effects (chorus, echo).
- On each codec sample strobe it writes the incoming sample at the write pointer and advances the pointer.
- It serves "sample N back" reads through the smart_ram interface: offset in, data plus one-cycle finish pulse out.
- It owns every SRAM control pin; effects never drive SRAM directly.

Parameters:
- DATA_WIDTH, 16: sample and SRAM word width.
- ADDR_WIDTH, 13: width of the effect-side byte offset (always even; LSB ignored).
- SRAM_ADDR_WIDTH, 18: SRAM word-address width; buffer depth is 2^SRAM_ADDR_WIDTH words.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-low reset.
- wr_valid  in  1  one-cycle strobe: new sample on wr_data.
- wr_data  in  DATA_WIDTH  signed sample to store.
- wr_done  out  1  one-cycle pulse: sample committed, pointer advanced.
- wr_drop  out  1  sticky: a wr_valid arrived while a write was still pending; cleared only by reset.
- sram_rd  in  1  one-cycle read request from the effect.
- sram_offset  in  ADDR_WIDTH  byte offset back from the newest sample.
- sram_data_in  out  DATA_WIDTH  read data (named from the effect's side).
- sram_read_finish  out  1  one-cycle pulse: sram_data_in valid.
- mem_addr  out  SRAM_ADDR_WIDTH  SRAM address.
- mem_dq_out  out  DATA_WIDTH  write data.
- mem_dq_in  in  DATA_WIDTH  read data from pad.
- mem_dq_oe  out  1  pad output enable.
- mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n  out  1 each  active-low SRAM strobes.

Behaviour:
- Reset (async, rst=0):
  - wr_ptr=0; pending flags clear; state IDLE.
  - sram_data_in=0; sram_read_finish=0; wr_done=0; wr_drop=0.
  - mem_ce_n=mem_oe_n=mem_we_n=mem_ub_n=mem_lb_n=1; mem_dq_oe=0; mem_addr=0.
  - Reset asserted mid-access deasserts mem_we_n immediately; that write is lost and the pointer does not advance.
- wr_ptr semantics:
  - wr_ptr is the next word to write; the newest sample is at wr_ptr-1.
  - Read word address = (wr_ptr - 1 - sram_offset[ADDR_WIDTH-1:1]) mod 2^SRAM_ADDR_WIDTH.
  - The address is computed and latched in the cycle sram_rd is sampled, using wr_ptr at that edge.
  - An offset reaching before the first written sample returns whatever the SRAM holds; the block does no check.
- Request capture (every state):
  - wr_valid sets wr_pend and latches wr_data. If wr_pend is already set, the new data overwrites it and wr_drop sets.
  - sram_rd sets rd_pend. It is ignored while rd_pend is set or a read is in progress.
- Arbitration in IDLE: wr_pend wins over rd_pend. Both may be captured in the same cycle; the write runs first and the latched read address is unaffected by that write.
- States:
  - IDLE: strobes inactive; dispatch to WR1 or RD1.
  - WR1: mem_addr=wr_ptr; dq_oe=1; ce_n=0, ub_n=0, lb_n=0; we_n=1.
  - WR2: we_n=0.
  - WR3: we_n=1, data and address held; clear wr_pend; wr_ptr+1 (wraps mod 2^SRAM_ADDR_WIDTH); -> IDLE with wr_done=1 in the next cycle.
  - RD1: mem_addr=latched address; ce_n=0, oe_n=0; dq_oe=0.
  - RD2: capture mem_dq_in into sram_data_in at the end of the cycle; clear rd_pend; -> IDLE.
- Read latency:
  - sram_rd at edge T, no write pending: RD1 at T+1, RD2 at T+2, sram_read_finish=1 during T+3 (state IDLE).
  - A new sram_rd in cycle T+4 is accepted, which matches the chorus pattern: rd issued one cycle after finish.
  - A waiting write adds 4 cycles.
- sram_data_in holds its value until the next read completes. sram_read_finish and wr_done are registered single-cycle pulses.

Decomposition:
- Shared package (audio_pkg):
  - State encodings.
  - DATA_WIDTH default.
  - Function delay_to_off(ms) = 2*ms*SAMPLERATE/1000, reused by all delay effects.
- One sub-module: delay_addr_gen, which holds wr_ptr, the increment and the offset subtraction/wrap. The FSM and pad logic stay in the top.

Test Plan:
- Write 0x0011, 0x0022, 0x0033; read offsets 0, 2, 4 -> sram_data_in 0x0033, 0x0022, 0x0011; each finish exactly 3 cycles after its sram_rd.
- SRAM_ADDR_WIDTH=4: write 20 samples 1..20; read offset 0 -> 20, offset 30 -> 5; mem_addr of the 17th write is 0.
- sram_rd and wr_valid (0x7FFF) in the same cycle, newest prior sample 0x0100, offset 0 -> write completes first (wr_done), then finish with 0x0100.
- Chorus sequence: three reads, each issued 1 cycle after the previous finish -> all three accepted; finishes 4 cycles apart; no dropped requests.
- Two wr_valid 1 cycle apart (0xAAAA then 0x5555) -> one write of 0x5555; wr_drop=1; wr_ptr +1 only.
- rst low during WR2 -> mem_we_n=1 within the same cycle; after release wr_ptr=0, all outputs at reset values.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared state encodings, default widths and delay helpers for the time-based effects
package audio_pkg;
    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int SAMPLERATE = 48000;
    typedef enum logic [2:0] {ST_IDLE, ST_WR1, ST_WR2, ST_WR3, ST_RD1, ST_RD2} dl_state_t;
    function automatic int delay_to_off(input int ms);
        return 2 * ms * SAMPLERATE / 1000;
    endfunction
endpackage

// File: rtl/delay_addr_gen.sv
// delay_addr_gen: circular write pointer and "N samples back" read address latch
module delay_addr_gen #(
    parameter int ADDR_WIDTH = 13,
    parameter int SRAM_ADDR_WIDTH = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       advance,
    input  logic                       capture,
    input  logic [ADDR_WIDTH-2:0]      offset_words,
    output logic [SRAM_ADDR_WIDTH-1:0] wr_ptr,
    output logic [SRAM_ADDR_WIDTH-1:0] rd_addr
);
    // Subtraction modulo the buffer depth, so only the low address bits of the offset matter
    logic [SRAM_ADDR_WIDTH-1:0] off_w;
    assign off_w = SRAM_ADDR_WIDTH'(offset_words);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_addr <= '0;
        end else begin
            if (advance) wr_ptr <= wr_ptr + 1'b1;
            if (capture) rd_addr <= wr_ptr - off_w - 1'b1;
        end
    end
endmodule

// File: rtl/delay_line_sram_ctrl.sv
// delay_line_sram_ctrl: circular sample delay line on external 16-bit SRAM,
// owning all SRAM strobes and serving offset-back reads to the effects.
module delay_line_sram_ctrl
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = 13,
    parameter int SRAM_ADDR_WIDTH = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    output logic                       wr_done,
    output logic                       wr_drop,
    input  logic                       sram_rd,
    input  logic [ADDR_WIDTH-1:0]      sram_offset,
    output logic [DATA_WIDTH-1:0]      sram_data_in,
    output logic                       sram_read_finish,
    output logic [SRAM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_dq_out,
    input  logic [DATA_WIDTH-1:0]      mem_dq_in,
    output logic                       mem_dq_oe,
    output logic                       mem_ce_n,
    output logic                       mem_oe_n,
    output logic                       mem_we_n,
    output logic                       mem_ub_n,
    output logic                       mem_lb_n
);
    dl_state_t state, state_nx;
    logic wr_pend, rd_pend, rd_take, wr_ph, rd_ph;
    logic [DATA_WIDTH-1:0] wr_buf;
    logic [SRAM_ADDR_WIDTH-1:0] wr_ptr, rd_addr;
    logic unused_offset_lsb;
    assign unused_offset_lsb = sram_offset[0];
    assign rd_take = sram_rd & !rd_pend;
    delay_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .SRAM_ADDR_WIDTH(SRAM_ADDR_WIDTH)
    ) u_ag (
        .clk(clk),
        .rst(rst),
        .advance(state == ST_WR3),
        .capture(rd_take),
        .offset_words(sram_offset[ADDR_WIDTH-1:1]),
        .wr_ptr(wr_ptr),
        .rd_addr(rd_addr)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= ST_IDLE;
            wr_pend          <= 1'b0;
            rd_pend          <= 1'b0;
            wr_buf           <= '0;
            wr_drop          <= 1'b0;
            wr_done          <= 1'b0;
            sram_read_finish <= 1'b0;
            sram_data_in     <= '0;
        end else begin
            state            <= state_nx;
            wr_pend          <= wr_valid | (wr_pend & (state != ST_WR3));
            rd_pend          <= rd_take | (rd_pend & (state != ST_RD2));
            wr_done          <= state == ST_WR3;
            sram_read_finish <= state == ST_RD2;
            if (wr_valid) wr_buf <= wr_data;
            if (wr_valid & wr_pend) wr_drop <= 1'b1;
            if (state == ST_RD2) sram_data_in <= mem_dq_in;
        end
    end
    // Strobes decode straight from state so an async reset releases them at once
    always_comb begin
        state_nx   = ST_IDLE;
        wr_ph      = state inside {ST_WR1, ST_WR2, ST_WR3};
        rd_ph      = state inside {ST_RD1, ST_RD2};
        case (state)
            ST_IDLE: state_nx = wr_pend ? ST_WR1 : (rd_pend ? ST_RD1 : ST_IDLE);
            ST_WR1:  state_nx = ST_WR2;
            ST_WR2:  state_nx = ST_WR3;
            ST_RD1:  state_nx = ST_RD2;
            default: state_nx = ST_IDLE;
        endcase
        mem_ce_n   = !(wr_ph | rd_ph);
        mem_ub_n   = !(wr_ph | rd_ph);
        mem_lb_n   = !(wr_ph | rd_ph);
        mem_we_n   = state != ST_WR2;
        mem_oe_n   = !rd_ph;
        mem_dq_oe  = wr_ph;
        mem_addr   = wr_ph ? wr_ptr : (rd_ph ? rd_addr : '0);
        mem_dq_out = wr_buf;
    end
endmodule

// File: tb/tb_delay_line_sram_ctrl.sv
// tb_delay_line_sram_ctrl: directed bench with a 16-word SRAM model behind the controller
module tb_delay_line_sram_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = '0;
    logic        wr_done, wr_drop;
    logic        sram_rd = 1'b0;
    logic [12:0] sram_offset = '0;
    logic [15:0] sram_data_in;
    logic        sram_read_finish;
    logic [3:0]  mem_addr;
    logic [15:0] mem_dq_out, mem_dq_in;
    logic        mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n;
    logic [15:0] mem [16];
    int n_asserts = 0;
    int n_fail = 0;

    delay_line_sram_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(13), .SRAM_ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_done(wr_done), .wr_drop(wr_drop),
        .sram_rd(sram_rd), .sram_offset(sram_offset),
        .sram_data_in(sram_data_in), .sram_read_finish(sram_read_finish),
        .mem_addr(mem_addr), .mem_dq_out(mem_dq_out), .mem_dq_in(mem_dq_in), .mem_dq_oe(mem_dq_oe),
        .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
        .mem_ub_n(mem_ub_n), .mem_lb_n(mem_lb_n)
    );

    always #5 clk = ~clk;

    // The SRAM commits on the edge that ends a we_n-low cycle
    always @(posedge clk)
        if (!mem_we_n && !mem_ce_n) mem[mem_addr] <= mem_dq_out;
    assign mem_dq_in = mem_oe_n ? 16'h0000 : mem[mem_addr];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] d, output logic [3:0] waddr);
        logic seen = 1'b0;
        logic done = 1'b0;
        waddr = 4'hx;
        wr_valid = 1'b1;
        wr_data = d;
        tick;
        wr_valid = 1'b0;
        for (int k = 0; k < 12 && !done; k++) begin
            tick;
            if (mem_dq_oe && !seen) begin
                seen = 1'b1;
                waddr = mem_addr;
            end
            done = wr_done;
        end
        chk("wr_done", {31'd0, done}, 32'd1);
    endtask

    task automatic do_read(input logic [12:0] off, input logic [15:0] exp);
        int lat = 0;
        logic fin = 1'b0;
        sram_rd = 1'b1;
        sram_offset = off;
        tick;
        sram_rd = 1'b0;
        for (int k = 0; k < 12 && !fin; k++) begin
            tick;
            lat++;
            fin = sram_read_finish;
        end
        chk("rd_latency", 32'(lat), 32'd3);
        chk("rd_data", {16'd0, sram_data_in}, {16'd0, exp});
    endtask

    initial begin
        logic [3:0] a;
        int done_at, fin_at, n_done, nf;
        int fin[3];
        logic [15:0] got[3];
        logic [12:0] offs[3];
        // reset values
        #2;
        chk("rst_data", {16'd0, sram_data_in}, 32'd0);
        chk("rst_fin", {31'd0, sram_read_finish}, 32'd0);
        chk("rst_done", {31'd0, wr_done}, 32'd0);
        chk("rst_drop", {31'd0, wr_drop}, 32'd0);
        chk("rst_strobes", {27'd0, mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n}, 32'h1f);
        chk("rst_oe", {31'd0, mem_dq_oe}, 32'd0);
        chk("rst_addr", {28'd0, mem_addr}, 32'd0);
        tick;
        rst = 1'b1;
        tick;
        // basic write/read-back
        do_write(16'h0011, a);
        chk("wr1_addr", {28'd0, a}, 32'd0);
        do_write(16'h0022, a);
        do_write(16'h0033, a);
        chk("wr3_addr", {28'd0, a}, 32'd2);
        do_read(13'd0, 16'h0033);
        do_read(13'd2, 16'h0022);
        do_read(13'd4, 16'h0011);
        // wraparound with a 16-word buffer
        rst = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        for (int i = 1; i <= 20; i++) begin
            do_write(16'(i), a);
            if (i == 17) chk("wr17_addr", {28'd0, a}, 32'd0);
        end
        do_read(13'd0, 16'd20);
        do_read(13'd30, 16'd5);
        // simultaneous write and read: write first, read sees prior newest
        do_write(16'h0100, a);
        wr_valid = 1'b1;
        wr_data = 16'h7FFF;
        sram_rd = 1'b1;
        sram_offset = 13'd0;
        tick;
        wr_valid = 1'b0;
        sram_rd = 1'b0;
        done_at = 0;
        fin_at = 0;
        for (int k = 1; k <= 12; k++) begin
            tick;
            if (wr_done) done_at = k;
            if (sram_read_finish) fin_at = k;
        end
        chk("both_done_at", 32'(done_at), 32'd4);
        chk("both_fin_at", 32'(fin_at), 32'd7);
        chk("both_data", {16'd0, sram_data_in}, 32'h0100);
        do_read(13'd0, 16'h7FFF);
        // chorus pattern: re-issue immediately after each finish
        offs[0] = 13'd0;
        offs[1] = 13'd2;
        offs[2] = 13'd4;
        nf = 0;
        sram_rd = 1'b1;
        sram_offset = offs[0];
        tick;
        sram_rd = 1'b0;
        for (int k = 1; k <= 20 && nf < 3; k++) begin
            tick;
            sram_rd = 1'b0;
            if (sram_read_finish) begin
                fin[nf] = k;
                got[nf] = sram_data_in;
                nf++;
                if (nf < 3) begin
                    sram_rd = 1'b1;
                    sram_offset = offs[nf];
                end
            end
        end
        chk("chorus_count", 32'(nf), 32'd3);
        chk("chorus_gap1", 32'(fin[1] - fin[0]), 32'd4);
        chk("chorus_gap2", 32'(fin[2] - fin[1]), 32'd4);
        chk("chorus_d0", {16'd0, got[0]}, 32'h7FFF);
        chk("chorus_d1", {16'd0, got[1]}, 32'h0100);
        chk("chorus_d2", {16'd0, got[2]}, 32'd20);
        chk("chorus_nodrop", {31'd0, wr_drop}, 32'd0);
        // back-to-back wr_valid: second overwrites, drop flagged
        wr_valid = 1'b1;
        wr_data = 16'hAAAA;
        tick;
        wr_data = 16'h5555;
        tick;
        wr_valid = 1'b0;
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            tick;
            if (wr_done) n_done++;
        end
        chk("drop_ndone", 32'(n_done), 32'd1);
        chk("drop_flag", {31'd0, wr_drop}, 32'd1);
        chk("drop_ptr", {28'd0, dut.u_ag.wr_ptr}, 32'd7);
        chk("drop_mem", {16'd0, mem[6]}, 32'h5555);
        do_read(13'd0, 16'h5555);
        // reset during WR2
        wr_valid = 1'b1;
        wr_data = 16'h1234;
        tick;
        wr_valid = 1'b0;
        tick;
        tick;
        chk("wr2_we_low", {31'd0, mem_we_n}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_we_n", {31'd0, mem_we_n}, 32'd1);
        chk("rst2_strobes", {27'd0, mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n}, 32'h1f);
        chk("rst2_oe", {31'd0, mem_dq_oe}, 32'd0);
        chk("rst2_addr", {28'd0, mem_addr}, 32'd0);
        chk("rst2_drop", {31'd0, wr_drop}, 32'd0);
        chk("rst2_data", {16'd0, sram_data_in}, 32'd0);
        tick;
        rst = 1'b1;
        tick;
        tick;
        chk("rst2_ptr", {28'd0, dut.u_ag.wr_ptr}, 32'd0);
        chk("rst2_idle_ce", {31'd0, mem_ce_n}, 32'd1);
        chk("rst2_done", {31'd0, wr_done}, 32'd0);
        do_write(16'h0BEE, a);
        chk("post_rst_addr", {28'd0, a}, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
